// File: rtl/endian_swap_arbiter.sv
// Round-robin arbiter in front of one registered byte-order swap engine (16/32/48/64-bit).
// Define SWAP_ARB_STATS_EN to add per-requester accept counters (stat_cnt, stat_clr).
module endian_swap_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*64-1:0] req_data,
  input  logic [N_REQ*2-1:0]  req_size,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [1:0]          resp_size,
  output logic [63:0]         resp_data
`ifdef SWAP_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [N_REQ*32-1:0] stat_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_accept;
  logic            accept;
  logic [63:0]     sel_data;
  logic [1:0]      sel_size;

  // Reverses the low 2/4/6/8 bytes; everything above the operand size reads as zero.
  function automatic logic [63:0] swap_bytes(input logic [63:0] d, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      2'd0:    r = {48'h0, d[7:0], d[15:8]};
      2'd1:    r = {32'h0, d[7:0], d[15:8], d[23:16], d[31:24]};
      2'd2:    r = {16'h0, d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
      default: r = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40], d[55:48], d[63:56]};
    endcase
    return r;
  endfunction

  assign can_accept = (state_q == EMPTY) || resp_ready;
  assign accept     = grant_found && can_accept;
  assign resp_valid = (state_q == FULL);

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data = req_data[grant_idx*64 +: 64];
    sel_size = req_size[grant_idx*2 +: 2];
  end

  always_comb begin
    state_d = state_q;
    if (accept)                         state_d = FULL;
    else if (state_q == FULL && resp_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: the result registers are reset too, so a discarded result never lingers on resp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= ID_W'(N_REQ - 1);
      resp_id   <= '0;
      resp_size <= '0;
      resp_data <= '0;
    end else if (accept) begin
      ptr_q     <= grant_idx;
      resp_id   <= grant_idx;
      resp_size <= sel_size;
      resp_data <= swap_bytes(sel_data, sel_size);
    end
  end

`ifdef SWAP_ARB_STATS_EN
  // Clear beats a same-cycle accept; counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == ID_W'(i)) stat_cnt[i*32 +: 32] <= stat_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_endian_swap_arbiter.sv
// Directed bench for endian_swap_arbiter: swaps, fairness, backpressure, reset and optional counters.
`timescale 1ns/1ps
module tb_endian_swap_arbiter;
  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_data;
  logic [N*2-1:0]  req_size;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [1:0]      resp_size;
  logic [63:0]     resp_data;
`ifdef SWAP_ARB_STATS_EN
  logic            stat_clr;
  logic [N*32-1:0] stat_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  endian_swap_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_size(resp_size), .resp_data(resp_data)
`ifdef SWAP_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid  = '0;
    req_data   = '0;
    req_size   = '0;
    resp_ready = 1'b0;
`ifdef SWAP_ARB_STATS_EN
    stat_clr   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester i presents size-0 data whose low bytes are {A0+i, 50+i} over junk upper bits.
  task automatic load_all_valid();
    for (int i = 0; i < N; i++) begin
      req_data[i*64 +: 64] = {48'hDEAD_BEEF_CAFE, 8'hA0 + 8'(i), 8'h50 + 8'(i)};
      req_size[i*2 +: 2]   = 2'd0;
    end
    req_valid = '1;
  endtask

  function automatic logic [63:0] fair_exp(input int i);
    return {48'h0, 8'h50 + 8'(i), 8'hA0 + 8'(i)};
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
    vectors++; if (resp_id !== '0) begin miscompares++; $display("FAIL reset_id got=%0d want=0", resp_id); end
    vectors++; if (resp_size !== 2'd0) begin miscompares++; $display("FAIL reset_size got=%0d want=0", resp_size); end
    vectors++; if (resp_data !== 64'h0) begin miscompares++; $display("FAIL reset_data got=%h want=0", resp_data); end
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", req_ready); end
  endtask

  task automatic test_single();
    int          ids  [6] = '{1, 2, 0, 3, 0, 1};
    logic [1:0]  szs  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [63:0] dats [6] = '{64'hABCD, 64'h1122_3344, 64'h0000_1122_3344_5566,
                              64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_1234, 64'hFFFF_FFFF_8899_AABB};
    logic [63:0] exps [6] = '{64'hCDAB, 64'h4433_2211, 64'h0000_6655_4433_2211,
                              64'h0807_0605_0403_0201, 64'h3412, 64'hBBAA_9988};
    for (int v = 0; v < 6; v++) begin
      clear_inputs();
      resp_ready = 1'b1;
      req_valid[ids[v]]            = 1'b1;
      req_data[ids[v]*64 +: 64]    = dats[v];
      req_size[ids[v]*2 +: 2]      = szs[v];
      #1;
      vectors++; if (req_ready !== N'(1 << ids[v])) begin miscompares++; $display("FAIL single%0d_ready got=%b want=%b", v, req_ready, N'(1 << ids[v])); end
      @(negedge clk);
      req_valid = '0;
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL single%0d_valid got=%b want=1", v, resp_valid); end
      vectors++; if (resp_id !== IW'(ids[v])) begin miscompares++; $display("FAIL single%0d_id got=%0d want=%0d", v, resp_id, ids[v]); end
      vectors++; if (resp_size !== szs[v]) begin miscompares++; $display("FAIL single%0d_size got=%0d want=%0d", v, resp_size, szs[v]); end
      vectors++; if (resp_data !== exps[v]) begin miscompares++; $display("FAIL single%0d_data got=%h want=%h", v, resp_data, exps[v]); end
    end
    @(negedge clk);
    #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got=%b want=0", resp_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    load_all_valid();
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++; if (req_ready !== N'(1 << (c % N))) begin miscompares++; $display("FAIL fair%0d_ready got=%b want=%b", c, req_ready, N'(1 << (c % N))); end
      @(negedge clk);
      vectors++; if (resp_valid !== 1'b1 || resp_id !== IW'(c % N)) begin miscompares++; $display("FAIL fair%0d_id got=%b/%0d want=1/%0d", c, resp_valid, resp_id, c % N); end
      vectors++; if (resp_data !== fair_exp(c % N)) begin miscompares++; $display("FAIL fair%0d_data got=%h want=%h", c, resp_data, fair_exp(c % N)); end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back_stall_and_reset();
    do_reset();
    load_all_valid();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL stall_ready0 got=%b want=0", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (resp_valid !== 1'b1 || resp_id !== IW'(0) || resp_data !== fair_exp(0)) begin
        miscompares++; $display("FAIL stall%0d_hold got=%b/%0d/%h want=1/0/%h", c, resp_valid, resp_id, resp_data, fair_exp(0));
      end
      vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL stall%0d_ready got=%b want=0", c, req_ready); end
    end
    resp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL release_ready got=%b want=0010", req_ready); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_id !== IW'(1) || resp_data !== fair_exp(1)) begin
      miscompares++; $display("FAIL release_id1 got=%b/%0d/%h want=1/1/%h", resp_valid, resp_id, resp_data, fair_exp(1));
    end
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL release_ready2 got=%b want=0100", req_ready); end
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_id !== IW'(2)) begin miscompares++; $display("FAIL release_id2 got=%b/%0d want=1/2", resp_valid, resp_id); end
    // Stall with a result pending, then reset: the result must vanish and ptr restart.
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (resp_valid !== 1'b0 || resp_id !== '0 || resp_data !== 64'h0) begin
      miscompares++; $display("FAIL midrst_state got=%b/%0d/%h want=0/0/0", resp_valid, resp_id, resp_data);
    end
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL midrst_ready got=%b want=0001", req_ready); end
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (resp_valid !== 1'b1 || resp_id !== IW'(0)) begin miscompares++; $display("FAIL midrst_first got=%b/%0d want=1/0", resp_valid, resp_id); end
    clear_inputs();
    @(negedge clk);
  endtask

`ifdef SWAP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    resp_ready = 1'b1;
    req_valid[2] = 1'b1;
    repeat (5) @(negedge clk);
    req_valid = '0;
    vectors++; if (stat_cnt[95:64] !== 32'd5) begin miscompares++; $display("FAIL stats_cnt2 got=%0d want=5", stat_cnt[95:64]); end
    vectors++; if (stat_cnt[31:0] !== 32'd0) begin miscompares++; $display("FAIL stats_cnt0 got=%0d want=0", stat_cnt[31:0]); end
    req_valid[2] = 1'b1;
    stat_clr = 1'b1;
    @(negedge clk);
    req_valid = '0;
    stat_clr = 1'b0;
    vectors++; if (stat_cnt[95:64] !== 32'd0) begin miscompares++; $display("FAIL stats_clr got=%0d want=0", stat_cnt[95:64]); end
    force dut.stat_cnt = {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7};
    #1;
    release dut.stat_cnt;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid = '0;
    vectors++; if (stat_cnt[95:64] !== 32'd0) begin miscompares++; $display("FAIL stats_wrap got=%h want=0", stat_cnt[95:64]); end
    vectors++; if (stat_cnt[31:0] !== 32'd7) begin miscompares++; $display("FAIL stats_other got=%0d want=7", stat_cnt[31:0]); end
    clear_inputs();
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back_stall_and_reset();
`ifdef SWAP_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
